// File: rtl/cello_sweep_pkg.sv
// ---------------------------------------------------------------------------
// cello_sweep_pkg
// Shared types and helpers for the truth-table sweeper.
//   state_t  : sweeper FSM states (IDLE, DRIVE, RESULT)
//   NUM_ROWS : number of input rows of a 3-input gate
//   row_bit  : maps a row index onto its bit position in a hex-named
//              truth-table word (row 000 -> bit 7, row 111 -> bit 0)
// ---------------------------------------------------------------------------
package cello_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam int NUM_ROWS = 8;

    function automatic logic [2:0] row_bit(input logic [2:0] idx);
        return 3'(NUM_ROWS - 1) - idx;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_counter.sv
// ---------------------------------------------------------------------------
// settle_counter
// Counts the cycles an input row has been held and flags the sampling cycle.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   clr  : synchronous clear (holds the count at zero)
//   en   : advance the count this cycle
//   tick : high while cnt == SETTLE_CYCLES-1 (sampling cycle)
// The count clears itself on the cycle after tick, so it never wraps.
// ---------------------------------------------------------------------------
module settle_counter #(
    parameter int CNT_W         = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(SETTLE_CYCLES - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper
// Walks a 3-input gate through all 8 input rows, holds each row for
// SETTLE_CYCLES cycles, samples the gate and reports the captured truth
// table against EXPECTED over a valid/ready result handshake.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   start     : request a sweep (accepted in IDLE only)
//   busy      : high in DRIVE and RESULT
//   in1..in3  : gate inputs, {in1,in2,in3} = row index
//   gate_out  : gate output, treated as synchronous to clk
//   res_valid : result available, held until res_ready
//   res_ready : consumer accepts the result
//   table_out : captured truth-table word (row 000 in bit 7)
//   mismatch  : table_out ^ EXPECTED
//   match     : result equals EXPECTED (qualified by res_valid)
// ---------------------------------------------------------------------------
module truth_table_sweeper
    import cello_sweep_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 4,
    parameter int         CNT_W         = 8,
    parameter logic [7:0] EXPECTED      = 8'h3E
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    input  logic       gate_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] table_out,
    output logic [7:0] mismatch,
    output logic       match
);

    state_t     state;
    state_t     next_state;
    logic [2:0] idx;
    logic [7:0] table_reg;
    logic [7:0] table_next;
    logic       tick;
    logic       last_row;

    settle_counter #(
        .CNT_W         (CNT_W),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != DRIVE),
        .en   (state == DRIVE),
        .tick (tick)
    );

    assign last_row = (idx == 3'(NUM_ROWS - 1));

    // Gate inputs come straight from the row register: no path from start.
    assign {in1, in2, in3} = idx;
    assign busy            = (state != IDLE);
    assign res_valid       = (state == RESULT);
    // mismatch resets to zero, so match must be gated by res_valid.
    assign match           = res_valid && (mismatch == 8'h00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        table_next = table_reg;
        table_next[row_bit(idx)] = gate_out;
        case (state)
            IDLE:    if (start)                 next_state = DRIVE;
            DRIVE:   if (tick && last_row)      next_state = RESULT;
            RESULT:  if (res_ready)             next_state = IDLE;
            default:                            next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            table_reg <= '0;
            table_out <= '0;
            mismatch  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        table_reg <= '0;
                    end
                end
                DRIVE: begin
                    if (tick) begin
                        table_reg <= table_next;
                        if (last_row) begin
                            // Result registers move only on entry to RESULT
                            // and hold through IDLE until the next sweep ends.
                            table_out <= table_next;
                            mismatch  <= table_next ^ EXPECTED;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                RESULT: begin
                    if (res_ready) idx <= '0;
                end
                default: idx <= '0;
            endcase
        end
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Upstream/downstream harness stage for a 3-input combinational logic gate such as the 0x3E truth-table gate.
- Drives the gate's in1/in2/in3 through all 8 input rows.
- Holds each row for a programmable settle time, then samples the gate output.
- Assembles an 8-bit truth-table word in the codebase's hex-naming bit order and compares it against an expected value.
- Sits between a test/config controller (start, result handshake) and the gate under test.

Parameters:
SETTLE_CYCLES, 4, cycles each input row is held before sampling; legal range 1..255.
CNT_W, 8, width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES.
EXPECTED, 8'h3E, reference truth-table word used for comparison.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a sweep; accepted only in IDLE.
busy  output  1  high in DRIVE and RESULT.
in1  output  1  gate input MSB of the row index.
in2  output  1  gate input middle bit of the row index.
in3  output  1  gate input LSB of the row index.
gate_out  input  1  output of the gate under test.
res_valid  output  1  result available; held until accepted.
res_ready  input  1  consumer accepts the result.
table_out  output  8  captured truth table.
mismatch  output  8  table_out XOR EXPECTED.
match  output  1  high when mismatch == 0; meaningful only while res_valid is high.

Behaviour:
Interface:
- One clock, clk.
- Reset rst is asynchronous and active-high.

Reset:
- State = IDLE; row index = 0; settle counter = 0; table register = 0.
- Outputs: busy = 0, in1/in2/in3 = 0, res_valid = 0, table_out = 0, mismatch = 0, match = 0.

Row index and bit order:
- Row index idx[2:0] = {in1,in2,in3}.
- in1..in3 are driven directly from the idx register, so there is no combinational path from start.
- Bit order: the sample for row idx goes to table[7-idx]. Row 000 maps to bit 7; row 111 maps to bit 0.
- Consequence: a correct 0x3E gate yields table_out = 8'h3E.

FSM:
- IDLE: start=1 -> DRIVE; idx=0, cnt=0, table=0. In all other cases remain in IDLE.
- DRIVE: each cycle cnt increments. When cnt==SETTLE_CYCLES-1:
  - Capture gate_out into table[7-idx] and clear cnt.
  - If idx==7 -> RESULT; otherwise idx increments.
- RESULT: res_valid=1. table_out and mismatch are held stable. res_valid && res_ready -> IDLE.

Timing:
- Latency: start accepted at edge E0; res_valid rises at edge E0 + 8*SETTLE_CYCLES.
- Each row is stable for exactly SETTLE_CYCLES cycles before its sampling edge.
- in1..in3 keep their last value (111) in RESULT and return to 000 on entering IDLE.
- table_out updates only on the transition into RESULT. It holds its value through IDLE until the next sweep finishes.

Boundary conditions:
- start while busy: ignored, with no effect on the sweep.
- start in the same cycle as the RESULT handshake: ignored; a new sweep needs start in IDLE.
- SETTLE_CYCLES=1: one row per cycle.
- Counter wrap is never reached (cnt clears at SETTLE_CYCLES-1).
- gate_out is treated as synchronous to clk. The caller must choose SETTLE_CYCLES to exceed the gate's propagation delay.
- rst mid-sweep or mid-RESULT: immediate return to reset values. The partial table is discarded.

Decomposition:
Shared package cello_sweep_pkg:
- state enum {IDLE, DRIVE, RESULT}.
- Constant NUM_ROWS=8.
- Function row_bit(idx) = 7-idx.

Sub-module settle_counter:
- Parameters CNT_W and SETTLE_CYCLES.
- Ports: clk, rst, clr, en, tick.
- tick is high when cnt==SETTLE_CYCLES-1.

Test Plan:
1. Ideal 0x3E gate model, SETTLE=4; pulse start -> res_valid at edge +32, table_out=8'h3E, mismatch=8'h00, match=1.
2. Gate stuck at 0 -> table_out=8'h00, mismatch=8'h3E, match=0; also stuck at 1 -> table_out=8'hFF, mismatch=8'hC1.
3. Backpressure: hold res_ready=0 for 10 cycles and pulse start during RESULT -> res_valid, table_out and in1..in3=111 stay stable, start ignored. Then res_ready=1 -> IDLE next cycle, in1..in3=000.
4. Assert rst asynchronously while idx=3 -> all outputs 0 immediately. A fresh start then yields 8'h3E at +32.
5. SETTLE_CYCLES=1 -> rows change every cycle, res_valid at edge +8, table_out=8'h3E.
6. Gate model with 3-cycle delay: SETTLE=4 -> 8'h3E, match=1. SETTLE=2 -> each row samples a stale value, match=0 (checked against the bench's golden model).
